jogo_sequencia_param: RTL and testbench

Parametrised memory-sequence game engine. It is the successor to the fixed 7-button, 16-step, single-level S1 datapath/control pair. It plays a stored sequence on LEDs, collects player presses, compares each press against sequence memory, and keeps score. Compared with S1 it adds:
- configurable button count, sequence depth and final length
- two round modes
- retry-with-penalty on error, with a lives limit
- a per-press timeout

It sits between the button/LED I/O and an external synchronous sequence ROM.

---
 rtl/jogo_sequencia_param.sv | 154 +++++++++++++++
 tb/tb_jogo_sequencia_param.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jogo_sequencia_param.sv
// jogo_sequencia_param: memory-sequence game engine (demo, press compare, score, lives, press timeout)
module jogo_sequencia_param #(
    parameter int N_BOTOES   = 7,
    parameter int ADDR_W     = 4,
    parameter int SCORE_W    = 7,
    parameter int SCORE_INIT = 100,
    parameter int PENALTY    = 10,
    parameter int MAX_ERROS  = 3,
    parameter int TIMEOUT    = 5000,
    parameter int SHOW_ON    = 500,
    parameter int SHOW_OFF   = 250
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                jogar,
    input  logic                modo,
    input  logic [ADDR_W-1:0]   limite,
    input  logic [N_BOTOES-1:0] botoes,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [N_BOTOES-1:0] mem_data,
    output logic [N_BOTOES-1:0] leds,
    output logic                pronto,
    output logic                acertou,
    output logic                errou,
    output logic [SCORE_W-1:0]  pontos,
    output logic [2:0]          erros,
    output logic [3:0]          db_estado,
    output logic                db_timeout
);
    localparam int CNT_MAX = (TIMEOUT > SHOW_ON) ? ((TIMEOUT > SHOW_OFF) ? TIMEOUT : SHOW_OFF)
                                                 : ((SHOW_ON > SHOW_OFF) ? SHOW_ON : SHOW_OFF);
    localparam int CNT_W = $clog2(CNT_MAX + 1);

    typedef enum logic [3:0] {
        S_INICIAL    = 4'h0,
        S_PREPARA    = 4'h1,
        S_MOSTRA_LE  = 4'h2,
        S_MOSTRA_ON  = 4'h3,
        S_MOSTRA_OFF = 4'h4,
        S_ESPERA     = 4'h5,
        S_COMPARA    = 4'h6,
        S_SOLTA      = 4'h7,
        S_PROX       = 4'h8,
        S_ERRO       = 4'h9,
        S_AGUARDA    = 4'hA,
        S_FIM_OK     = 4'hE,
        S_FIM_ERR    = 4'hF
    } estado_t;

    estado_t             r_state, w_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [ADDR_W-1:0]   r_idx, r_rodada, r_limite;
    logic [N_BOTOES-1:0] r_jogada, r_botoes_d;
    logic [SCORE_W-1:0]  r_pontos;
    logic [2:0]          r_erros;
    logic                r_jogar_d;

    logic w_idle, w_start, w_press, w_solto, w_last, w_tmo;

    assign w_idle  = (r_state == S_INICIAL) || (r_state == S_FIM_OK) || (r_state == S_FIM_ERR);
    assign w_start = jogar && !r_jogar_d && w_idle;
    assign w_press = (botoes != '0) && (r_botoes_d == '0);
    assign w_solto = (botoes == '0);
    assign w_last  = (r_idx == r_rodada);
    assign w_tmo   = (r_cnt == CNT_W'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= S_INICIAL;
        else        r_state <= w_next;
    end

    // Next-state logic; a press in the same cycle as the timeout wins
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_INICIAL, S_FIM_OK, S_FIM_ERR: if (w_start) w_next = S_PREPARA;
            S_PREPARA:    w_next = S_MOSTRA_LE;
            S_MOSTRA_LE:  w_next = S_MOSTRA_ON;
            S_MOSTRA_ON:  if (r_cnt == CNT_W'(SHOW_ON - 1)) w_next = S_MOSTRA_OFF;
            S_MOSTRA_OFF: if (r_cnt == CNT_W'(SHOW_OFF - 1)) w_next = w_last ? S_ESPERA : S_MOSTRA_LE;
            S_ESPERA:     if (w_press) w_next = S_COMPARA;
                          else if (w_tmo) w_next = S_ERRO;
            S_COMPARA:    w_next = (r_jogada == mem_data) ? S_SOLTA : S_ERRO;
            S_SOLTA:      if (w_solto) w_next = w_last ? S_PROX : S_ESPERA;
            S_PROX:       w_next = (r_rodada == r_limite) ? S_FIM_OK : S_PREPARA;
            S_ERRO:       w_next = ((r_erros + 3'd1) == 3'(MAX_ERROS)) ? S_FIM_ERR : S_AGUARDA;
            S_AGUARDA:    if (w_solto) w_next = S_PREPARA;
            default:      w_next = S_INICIAL;
        endcase
    end

    // Shared phase counter: restarts on every state change, runs only in timed states
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            r_cnt <= '0;
        else if (w_next != r_state)
            r_cnt <= '0;
        else if (r_state inside {S_MOSTRA_ON, S_MOSTRA_OFF, S_ESPERA})
            r_cnt <= r_cnt + 1'b1;
    end

    // Game datapath: start latch, step/round indices, press capture, score and lives
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_jogar_d  <= 1'b0;
            r_botoes_d <= '0;
            r_idx      <= '0;
            r_rodada   <= '0;
            r_limite   <= '0;
            r_jogada   <= '0;
            r_pontos   <= SCORE_W'(SCORE_INIT);
            r_erros    <= '0;
        end else begin
            r_jogar_d  <= jogar;
            r_botoes_d <= botoes;
            if (w_start) begin
                r_limite <= limite;
                r_rodada <= modo ? limite : '0;
                r_pontos <= SCORE_W'(SCORE_INIT);
                r_erros  <= '0;
            end
            if (r_state == S_PREPARA)
                r_idx <= '0;
            if (r_state == S_MOSTRA_OFF && w_next == S_MOSTRA_LE)
                r_idx <= r_idx + 1'b1;
            if (r_state == S_MOSTRA_OFF && w_next == S_ESPERA)
                r_idx <= '0;
            if (r_state == S_SOLTA && w_next == S_ESPERA)
                r_idx <= r_idx + 1'b1;
            if (r_state == S_ESPERA && w_press)
                r_jogada <= botoes;
            if (r_state == S_PROX && w_next == S_PREPARA)
                r_rodada <= r_rodada + 1'b1;
            if (r_state == S_ERRO) begin
                r_erros  <= r_erros + 3'd1;
                r_pontos <= (r_pontos < SCORE_W'(PENALTY)) ? '0 : r_pontos - SCORE_W'(PENALTY);
            end
        end
    end

    // Outputs decoded from state and datapath registers
    always_comb begin
        leds       = (r_state == S_MOSTRA_ON) ? mem_data : '0;
        pronto     = (r_state == S_FIM_OK) || (r_state == S_FIM_ERR);
        acertou    = (r_state == S_FIM_OK);
        errou      = (r_state == S_FIM_ERR);
        db_timeout = (r_state == S_ESPERA) && !w_press && w_tmo;
        db_estado  = r_state;
        mem_addr   = r_idx;
        pontos     = r_pontos;
        erros      = r_erros;
    end
endmodule

// File: tb/tb_jogo_sequencia_param.sv
// tb_jogo_sequencia_param: directed and randomized game play checked against a round/step game model
module tb_jogo_sequencia_param;
    localparam int NB = 7, AW = 4, SW = 7, SI = 100, PEN = 10, MAXE = 3;
    localparam int TMO = 30, SON = 6, SOFF = 4, BUDGET = 3000;

    logic          clock = 1'b0, reset = 1'b0, jogar = 1'b0, modo = 1'b0;
    logic [AW-1:0] limite = '0, mem_addr;
    logic [NB-1:0] botoes = '0, mem_data, leds;
    logic          pronto, acertou, errou, db_timeout;
    logic [SW-1:0] pontos;
    logic [2:0]    erros;
    logic [3:0]    db_estado;
    logic [NB-1:0] rom [16];
    int            n_tests = 0, n_fail = 0;

    jogo_sequencia_param #(
        .N_BOTOES(NB), .ADDR_W(AW), .SCORE_W(SW), .SCORE_INIT(SI), .PENALTY(PEN),
        .MAX_ERROS(MAXE), .TIMEOUT(TMO), .SHOW_ON(SON), .SHOW_OFF(SOFF)
    ) dut (
        .clock(clock), .reset(reset), .jogar(jogar), .modo(modo), .limite(limite),
        .botoes(botoes), .mem_addr(mem_addr), .mem_data(mem_data), .leds(leds),
        .pronto(pronto), .acertou(acertou), .errou(errou), .pontos(pontos),
        .erros(erros), .db_estado(db_estado), .db_timeout(db_timeout)
    );

    always #5 clock = ~clock;

    always @(posedge clock) mem_data <= rom[mem_addr];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_state(input logic [3:0] code, input string tag, output int n);
        n = 0;
        while (db_estado !== code && n < BUDGET) begin
            tick();
            n++;
        end
        chk(tag, 32'(db_estado), 32'(code));
    endtask

    task automatic watch_demo(input int r);
        int n;
        logic [NB-1:0] v;
        for (int s = 0; s <= r; s++) begin
            n = 0;
            while (leds === '0 && n < BUDGET) begin
                tick();
                n++;
            end
            v = leds;
            n = 0;
            while (leds === v && n < BUDGET) begin
                tick();
                n++;
            end
            chk("demo_symbol", v, rom[s]);
            chk("demo_on_cycles", n, SON);
        end
        wait_state(4'h5, "demo_to_espera", n);
        chk("demo_off_cycles", n, SOFF);
    endtask

    task automatic press(input logic [NB-1:0] v, input int hold);
        botoes = v;
        repeat (hold) tick();
        botoes = '0;
        tick();
    endtask

    task automatic start(input logic m, input logic [AW-1:0] l, input bit keep_high);
        modo = m;
        limite = l;
        jogar = 1'b0;
        tick();
        jogar = 1'b1;
        tick();
        if (!keep_high) jogar = 1'b0;
        chk("start_estado", db_estado, 1);
        chk("start_pontos", pontos, SI);
        chk("start_erros", erros, 0);
        chk("start_pronto", pronto, 0);
    endtask

    task automatic play_game(input logic m, input int lim, input int wrong_pct, input int tmo_pct,
                             input int dir_r, input int dir_s, input logic [NB-1:0] dir_v,
                             input int hold_fix, input int abort_r, input bit jp);
        int r, pts, ers, n, kind, hold, x;
        bit lost, ok, used;
        logic [NB-1:0] v;
        r = m ? lim : 0;
        pts = SI;
        ers = 0;
        lost = 0;
        used = 0;
        limite = AW'($urandom);
        modo = ~m;
        while (!lost && r <= lim) begin
            if (r == abort_r) begin
                n = 0;
                while (leds === '0 && n < BUDGET) begin
                    tick();
                    n++;
                end
                return;
            end
            watch_demo(r);
            ok = 1;
            for (int s = 0; s <= r && ok; s++) begin
                if (s > 0) wait_state(4'h5, "espera_next", n);
                if (jp && r == 1 && s == 0) begin
                    jogar = 1'b0;
                    tick();
                    jogar = 1'b1;
                    tick();
                    chk("jogar_in_espera_ignored", db_estado, 5);
                end
                if (!used && r == dir_r && s == dir_s) begin
                    used = 1;
                    v = dir_v;
                    kind = (v === rom[s]) ? 0 : 1;
                end else begin
                    x = $urandom_range(0, 99);
                    kind = (x < tmo_pct) ? 2 : (x < tmo_pct + wrong_pct) ? 1 : 0;
                    v = rom[s];
                    if (kind == 1) begin
                        v = NB'($urandom_range(1, (1 << NB) - 1));
                        if (v === rom[s]) v = v ^ 7'h03;
                    end
                end
                hold = (hold_fix > 0) ? hold_fix : $urandom_range(3, 12);
                if (kind == 2) begin
                    n = 1;
                    while (db_timeout !== 1'b1 && n < BUDGET) begin
                        tick();
                        n++;
                    end
                    chk("timeout_cycles", n, TMO);
                    tick();
                    chk("timeout_pulse_width", db_timeout, 0);
                    tick();
                end else begin
                    press(v, hold);
                end
                if (kind != 0) begin
                    ers++;
                    pts = (pts < PEN) ? 0 : pts - PEN;
                    ok = 0;
                    lost = (ers == MAXE);
                    chk("erros_after_error", erros, ers);
                    chk("pontos_after_error", pontos, pts);
                end
            end
            if (ok) r++;
        end
        n = 0;
        while (pronto !== 1'b1 && n < BUDGET) begin
            tick();
            n++;
        end
        chk("end_pronto", pronto, 1);
        chk("end_acertou", acertou, !lost);
        chk("end_errou", errou, lost);
        chk("end_pontos", pontos, pts);
        chk("end_erros", erros, ers);
        chk("end_estado", db_estado, lost ? 15 : 14);
    endtask

    initial begin
        logic [NB-1:0] base [16] = '{7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h40, 7'h20,
                                     7'h10, 7'h08, 7'h04, 7'h02, 7'h01, 7'h02, 7'h04, 7'h08};
        for (int i = 0; i < 16; i++) rom[i] = base[i];
        reset = 1'b0;
        repeat (3) tick();
        chk("reset_estado", db_estado, 0);
        chk("reset_pontos", pontos, SI);
        chk("reset_leds", leds, 0);
        chk("reset_pronto", pronto, 0);
        chk("reset_erros", erros, 0);
        chk("reset_addr", mem_addr, 0);
        chk("reset_timeout", db_timeout, 0);
        reset = 1'b1;
        tick();

        start(1'b0, 4'd15, 1'b0);
        play_game(1'b0, 15, 0, 0, -1, 0, '0, 100, -1, 1'b0);

        start(1'b0, 4'd15, 1'b0);
        play_game(1'b0, 15, 0, 0, 3, 1, 7'h04, 0, -1, 1'b0);

        start(1'b0, 4'd4, 1'b0);
        play_game(1'b0, 4, 0, 100, -1, 0, '0, 0, -1, 1'b0);
        press(7'h01, 5);
        chk("fim_erro_estado_held", db_estado, 15);
        chk("fim_erro_pontos_held", pontos, 70);
        chk("fim_erro_erros_held", erros, 3);
        chk("fim_erro_errou_held", errou, 1);

        start(1'b1, 4'd3, 1'b0);
        play_game(1'b1, 3, 0, 0, -1, 0, '0, 0, -1, 1'b0);
        start(1'b1, 4'd3, 1'b0);
        play_game(1'b1, 3, 0, 0, 3, 0, 7'h03, 0, -1, 1'b0);

        start(1'b0, 4'd15, 1'b0);
        play_game(1'b0, 15, 0, 0, -1, 0, '0, 0, 5, 1'b0);
        chk("abort_in_demo", leds !== '0, 1);
        #2 reset = 1'b0;
        #1;
        chk("async_reset_estado", db_estado, 0);
        chk("async_reset_leds", leds, 0);
        chk("async_reset_pontos", pontos, SI);
        chk("async_reset_addr", mem_addr, 0);
        chk("async_reset_pronto", pronto, 0);
        @(posedge clock);
        #2 reset = 1'b1;
        tick();
        start(1'b0, 4'd2, 1'b0);
        play_game(1'b0, 2, 0, 0, -1, 0, '0, 0, -1, 1'b0);

        start(1'b0, 4'd2, 1'b1);
        play_game(1'b0, 2, 0, 0, 2, 1, 7'h08, 0, -1, 1'b1);
        repeat (20) tick();
        chk("jogar_held_no_restart", db_estado, 14);
        chk("jogar_held_pontos", pontos, 90);
        modo = 1'b0;
        limite = 4'd1;
        jogar = 1'b0;
        tick();
        jogar = 1'b1;
        botoes = 7'h01;
        tick();
        botoes = '0;
        jogar = 1'b0;
        chk("restart_estado", db_estado, 1);
        chk("restart_pontos", pontos, SI);
        chk("restart_acertou", acertou, 0);
        play_game(1'b0, 1, 0, 0, -1, 0, '0, 0, -1, 1'b0);

        start(1'b0, 4'd0, 1'b0);
        play_game(1'b0, 0, 0, 0, -1, 0, '0, 0, -1, 1'b0);
        start(1'b1, 4'd0, 1'b0);
        play_game(1'b1, 0, 0, 0, -1, 0, '0, 0, -1, 1'b0);

        for (int k = 0; k < 8; k++) begin
            logic m;
            int lim;
            for (int i = 0; i < 16; i++) rom[i] = NB'(1 << $urandom_range(0, NB - 1));
            m = 1'($urandom_range(0, 1));
            lim = $urandom_range(0, 5);
            start(m, AW'(lim), 1'b0);
            play_game(m, lim, 15, 5, -1, 0, '0, 0, -1, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
